carry_select_adder16: RTL and testbench
=======================================

// Module: carry_select_adder16
// PURPOSE
//   Registered 16-bit carry-select adder computing A + B + Cin with a carry-out.
//   It is the fast counterpart to the plain ripple-carry adder (ripple16) in the
//   arithmetic datapath and must be bit-identical to it for every input.
//   The combinational carry-select core feeds one output register stage.
// PARAMETERS
//   WIDTH  16  operand and sum width; must be a multiple of BLOCK
//   BLOCK   4  carry-select block width in bits (WIDTH/BLOCK blocks)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      a, b and cin are sampled on this clock edge
//   a          in   WIDTH  operand A, unsigned / two's complement
//   b          in   WIDTH  operand B
//   cin        in   1      carry-in
//   sum        out  WIDTH  registered (a + b + cin) mod 2^WIDTH
//   cout       out  1      registered carry-out of the MSB
//   ovf        out  1      registered signed overflow
//   out_valid  out  1      sum, cout and ovf hold a new result
// BEHAVIOUR
//   - Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
//   - Reset: sum=0, cout=0, ovf=0, out_valid=0, applied immediately on rst_n low.
//     Release is synchronised to clk by the register flops.
//   - Latency: exactly 1 cycle. Operands sampled with in_valid=1 on edge N appear
//     on sum, cout and ovf after edge N, with out_valid=1.
//   - in_valid=0: sum, cout and ovf hold their previous values; out_valid=0.
//     No backpressure; a new operand may be accepted every cycle.
//   - Arithmetic: {cout,sum} = a + b + cin, with a (WIDTH+1)-bit exact result.
//     ovf = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]).
//   - Carry-select core:
//     - block 0 is a BLOCK-bit ripple adder driven by cin;
//     - every higher block k computes two sums in parallel, one with carry-in 0
//       and one with carry-in 1;
//     - the carry-out of block k-1 selects block k's sum and carry through a 2:1 mux;
//     - the selected carry of the last block is cout.
//   - Full propagation (a=FFFF, b=0000, cin=1) must yield sum=0000, cout=1.
//   - Reset asserted mid-stream discards the in-flight result; the first
//     out_valid follows the first in_valid after release.
//   - X/Z on the inputs is never masked: results are purely combinational from
//     the sampled bits.
// STRUCTURE
//   - Sub-module ripple_adder4: a 4-bit ripple-carry adder built from full adders
//     (s = a^b^c, co = ab | c(a^b)).
//   - Instances: one for block 0, two per upper block (carry-in 0 and 1), plus a
//     mux per upper block. Use a generate loop over WIDTH/BLOCK.
//   - No shared package is needed; WIDTH and BLOCK are local parameters only.
// TESTING (compare every result against ripple16 and against a + b + cin)
//   1. Reset: rst_n=0 for 2 cycles -> sum=0000, cout=0, ovf=0, out_valid=0.
//   2. a=F04E, b=BCA9, cin=1 -> sum=ACF8, cout=1; with cin=0 -> sum=ACF7, cout=1.
//   3. a=A477, b=91E5, cin=0 -> sum=365C, cout=1, ovf=1.
//   4. a=A457, b=75A5, cin=1 -> sum=19FD, cout=1, ovf=0.
//   5. a=FFFF, b=0000, cin=1 -> sum=0000, cout=1; a=7FFF, b=0001, cin=0 -> sum=8000,
//      cout=0, ovf=1.
//   6. Hold and reset: in_valid=0 -> outputs hold, out_valid=0. Pulse rst_n low
//      between two valid inputs -> outputs clear immediately; the next valid input
//      appears 1 cycle later.
//   Also run 10k random vectors against the golden model.

Source files
------------

// File: rtl/carry_select_adder16_pkg.sv
// Shared constants and helpers for the registered carry-select adder.
package carry_select_adder16_pkg;

    // Default operand width and carry-select block width
    localparam int CSA_WIDTH = 16;
    localparam int CSA_BLOCK = 4;

    // Signed overflow: both operands share a sign that the sum does not carry
    function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/carry_select_adder16_ripple_adder4.sv
// Ripple-carry adder block built from full adders; one carry-select building block.
module ripple_adder4 #(
    parameter int BITS = 4
) (
    input  logic [BITS-1:0] i_a,
    input  logic [BITS-1:0] i_b,
    input  logic            i_ci,
    output logic [BITS-1:0] o_s,
    output logic            o_co
);

    logic [BITS:0] w_c;

    assign w_c[0] = i_ci;

    // Each stage is a textbook full adder; carries ripple LSB to MSB
    for (genvar i = 0; i < BITS; i++) begin : g_fa
        assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_co = w_c[BITS];

endmodule

// File: rtl/carry_select_adder16.sv
// Registered carry-select adder: {cout,sum} = a + b + cin, plus signed overflow.
// Block 0 ripples from cin; every upper block precomputes both carry-in cases
// and the carry of the block below picks one, so the critical path is one
// block ripple plus a chain of 2:1 muxes.
module carry_select_adder16
    import carry_select_adder16_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int BLOCK = CSA_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);

    localparam int NBLK = WIDTH / BLOCK;

    // w_carry[k] is the selected carry into block k; w_carry[NBLK] is the MSB carry-out
    logic [NBLK:0]    w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_valid;

    assign w_carry[0] = cin;

    for (genvar k = 0; k < NBLK; k++) begin : g_blk
        if (k == 0) begin : g_first
            // Lowest block has a real carry-in, so a single ripple adder suffices
            ripple_adder4 #(.BITS(BLOCK)) u_rca (
                .i_a  (a[BLOCK-1:0]),
                .i_b  (b[BLOCK-1:0]),
                .i_ci (w_carry[0]),
                .o_s  (w_sum[BLOCK-1:0]),
                .o_co (w_carry[1])
            );
        end else begin : g_sel
            logic [BLOCK-1:0] w_s0;
            logic [BLOCK-1:0] w_s1;
            logic             w_c0;
            logic             w_c1;

            // Speculative sum assuming no carry into this block
            ripple_adder4 #(.BITS(BLOCK)) u_rca0 (
                .i_a  (a[k*BLOCK +: BLOCK]),
                .i_b  (b[k*BLOCK +: BLOCK]),
                .i_ci (1'b0),
                .o_s  (w_s0),
                .o_co (w_c0)
            );

            // Speculative sum assuming a carry into this block
            ripple_adder4 #(.BITS(BLOCK)) u_rca1 (
                .i_a  (a[k*BLOCK +: BLOCK]),
                .i_b  (b[k*BLOCK +: BLOCK]),
                .i_ci (1'b1),
                .o_s  (w_s1),
                .o_co (w_c1)
            );

            // Carry from the block below selects the matching speculative result
            assign w_sum[k*BLOCK +: BLOCK] = w_carry[k] ? w_s1 : w_s0;
            assign w_carry[k+1]            = w_carry[k] ? w_c1 : w_c0;
        end
    end

    assign w_ovf = ovf_f(a[WIDTH-1], b[WIDTH-1], w_sum[WIDTH-1]);

    // Result register: load on in_valid, hold otherwise; valid tracks in_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum   <= {WIDTH{1'b0}};
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_carry[NBLK];
                r_ovf  <= w_ovf;
            end else begin
                r_sum  <= r_sum;
                r_cout <= r_cout;
                r_ovf  <= r_ovf;
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_carry_select_adder16.sv
// Directed and random checks of carry_select_adder16 against a + b + cin.
module tb_carry_select_adder16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        out_valid;

    int n_vec;
    int n_err;

    // Packed view {out_valid, ovf, cout, sum}
    logic [18:0] obs;
    assign obs = {out_valid, ovf, cout, sum};

    carry_select_adder16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a valid operand set between edges and sample just after the next edge
    task automatic drive(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
        @(negedge clk);
        a        = ta;
        b        = tb;
        cin      = tc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        cin      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (obs !== 19'h0) begin
            n_err++;
            $display("FAIL reset: got %h want %h", obs, 19'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (obs !== 19'h0) begin
            n_err++;
            $display("FAIL reset_release_idle: got %h want %h", obs, 19'h0);
        end
    endtask

    task automatic test_directed();
        drive(16'hF04E, 16'hBCA9, 1'b1);
        n_vec++;
        if (obs !== {1'b1, 1'b0, 1'b1, 16'hACF8}) begin
            n_err++;
            $display("FAIL f04e_bca9_c1: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 16'hACF8});
        end
        drive(16'hF04E, 16'hBCA9, 1'b0);
        n_vec++;
        if (obs !== {1'b1, 1'b0, 1'b1, 16'hACF7}) begin
            n_err++;
            $display("FAIL f04e_bca9_c0: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 16'hACF7});
        end
        drive(16'hA477, 16'h91E5, 1'b0);
        n_vec++;
        if (obs !== {1'b1, 1'b1, 1'b1, 16'h365C}) begin
            n_err++;
            $display("FAIL a477_91e5_ovf: got %h want %h", obs, {1'b1, 1'b1, 1'b1, 16'h365C});
        end
        drive(16'hA457, 16'h75A5, 1'b1);
        n_vec++;
        if (obs !== {1'b1, 1'b0, 1'b1, 16'h19FD}) begin
            n_err++;
            $display("FAIL a457_75a5: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 16'h19FD});
        end
    endtask

    task automatic test_boundary();
        drive(16'hFFFF, 16'h0000, 1'b1);
        n_vec++;
        if (obs !== {1'b1, 1'b0, 1'b1, 16'h0000}) begin
            n_err++;
            $display("FAIL full_propagate: got %h want %h", obs, {1'b1, 1'b0, 1'b1, 16'h0000});
        end
        drive(16'h7FFF, 16'h0001, 1'b0);
        n_vec++;
        if (obs !== {1'b1, 1'b1, 1'b0, 16'h8000}) begin
            n_err++;
            $display("FAIL pos_overflow: got %h want %h", obs, {1'b1, 1'b1, 1'b0, 16'h8000});
        end
        drive(16'h8000, 16'h8000, 1'b0);
        n_vec++;
        if (obs !== {1'b1, 1'b1, 1'b1, 16'h0000}) begin
            n_err++;
            $display("FAIL neg_overflow: got %h want %h", obs, {1'b1, 1'b1, 1'b1, 16'h0000});
        end
        drive(16'h000F, 16'h0001, 1'b0);
        n_vec++;
        if (obs !== {1'b1, 1'b0, 1'b0, 16'h0010}) begin
            n_err++;
            $display("FAIL block0_carry: got %h want %h", obs, {1'b1, 1'b0, 1'b0, 16'h0010});
        end
        drive(16'h0FFF, 16'h0000, 1'b1);
        n_vec++;
        if (obs !== {1'b1, 1'b0, 1'b0, 16'h1000}) begin
            n_err++;
            $display("FAIL select_chain: got %h want %h", obs, {1'b1, 1'b0, 1'b0, 16'h1000});
        end
    endtask

    task automatic test_hold();
        drive(16'h1234, 16'h4321, 1'b1);
        n_vec++;
        if (obs !== {1'b1, 1'b0, 1'b0, 16'h5556}) begin
            n_err++;
            $display("FAIL hold_load: got %h want %h", obs, {1'b1, 1'b0, 1'b0, 16'h5556});
        end
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        cin      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (obs !== {1'b0, 1'b0, 1'b0, 16'h5556}) begin
            n_err++;
            $display("FAIL hold_idle: got %h want %h", obs, {1'b0, 1'b0, 1'b0, 16'h5556});
        end
    endtask

    task automatic test_reset_midstream();
        drive(16'hA477, 16'h91E5, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_vec++;
        if (obs !== 19'h0) begin
            n_err++;
            $display("FAIL midreset_clear: got %h want %h", obs, 19'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (obs !== 19'h0) begin
            n_err++;
            $display("FAIL midreset_no_valid: got %h want %h", obs, 19'h0);
        end
        drive(16'h7FFF, 16'h0001, 1'b0);
        n_vec++;
        if (obs !== {1'b1, 1'b1, 1'b0, 16'h8000}) begin
            n_err++;
            $display("FAIL midreset_first: got %h want %h", obs, {1'b1, 1'b1, 1'b0, 16'h8000});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [4] = '{16'h0001, 16'hFFFF, 16'h8000, 16'h5555};
        logic [15:0] vb [4] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'hAAAA};
        logic        vc [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [18:0] ve [4] = '{{1'b1, 1'b0, 1'b0, 16'h0002},
                                {1'b1, 1'b0, 1'b1, 16'hFFFF},
                                {1'b1, 1'b0, 1'b1, 16'h0000},
                                {1'b1, 1'b0, 1'b1, 16'h0000}};
        for (int i = 0; i < 4; i++) begin
            drive(va[i], vb[i], vc[i]);
            n_vec++;
            if (obs !== ve[i]) begin
                n_err++;
                $display("FAIL b2b_%0d: got %h want %h", i, obs, ve[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] ex;
        logic        eo;
        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            ex = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            eo = (ra[15] == rb[15]) && (ex[15] != ra[15]);
            drive(ra, rb, rc);
            n_vec++;
            if (obs !== {1'b1, eo, ex}) begin
                n_err++;
                $display("FAIL random_%0d a=%h b=%h cin=%b: got %h want %h",
                         i, ra, rb, rc, obs, {1'b1, eo, ex});
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_boundary();
        test_hold();
        test_reset_midstream();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
